cache_cmd_dispatch: RTL and testbench

Front-end stage of the L1 cache model. It accepts trace commands (command code plus 32-bit address), buffers them in a small FIFO, and splits each address into tag, index and offset. It routes each command to the data-cache or instruction-cache lookup port, sequences CLR across both caches, and keeps read, write and fetch counters. It sits directly upstream of the D-cache (8-way) and I-cache (4-way) lookup stages.

---
 rtl/mypkg.sv | 40 ++++
 rtl/cmd_fifo.sv | 56 +++++
 rtl/cache_cmd_dispatch.sv | 198 +++++++++++++++++++
 tb/tb_cache_cmd_dispatch.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mypkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mypkg : command codes, address-field widths and FIFO entry type
// Rev 1.0
// -----------------------------------------------------------------------------
package mypkg;
  localparam int CMD_W       = 4;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 14;
  localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [CMD_W-1:0] {
    READ       = 4'd0,
    WRITE      = 4'd1,
    I_FETCH    = 4'd2,
    L2_INVAL   = 4'd3,
    L2_DATA_RQ = 4'd4,
    CLR        = 4'd8,
    PRINT      = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_CLR_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [CMD_W-1:0]     cmd;
    logic [ADDR_BITS-1:0] addr;
  } cmd_entry_t;

  localparam int ENTRY_W = $bits(cmd_entry_t);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cmd_fifo : synchronous FIFO with registered count, full/empty flags
// Rev 1.0
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/cache_cmd_dispatch.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cache_cmd_dispatch : buffers trace commands and routes them to D/I caches
// Rev 1.0
// -----------------------------------------------------------------------------
module cache_cmd_dispatch
  import mypkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ADDR_BITS,
  parameter int OFFSET_W   = OFFSET_BITS,
  parameter int INDEX_W    = INDEX_BITS,
  parameter int TAG_W      = TAG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CMD_W-1:0]    in_cmd,
  input  logic [ADDR_W-1:0]   in_addr,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [CMD_W-1:0]    d_cmd,
  output logic [TAG_W-1:0]    d_tag,
  output logic [INDEX_W-1:0]  d_index,
  output logic [OFFSET_W-1:0] d_offset,
  output logic                i_valid,
  input  logic                i_ready,
  output logic                i_inval,
  output logic [TAG_W-1:0]    i_tag,
  output logic [INDEX_W-1:0]  i_index,
  output logic [OFFSET_W-1:0] i_offset,
  output logic                clr_req,
  input  logic                clr_ack_d,
  input  logic                clr_ack_i,
  output logic                print_pulse,
  output logic                bad_cmd,
  output logic [31:0]         cnt_read,
  output logic [31:0]         cnt_write,
  output logic [31:0]         cnt_fetch,
  output logic                busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  cmd_entry_t         push_entry, head;
  logic               fifo_full, fifo_empty, push, pop, more;
  logic [CNT_W-1:0]   fifo_count;
  state_e             state_q, state_d;
  logic               d_done_q, d_done_d, i_done_q, i_done_d;
  logic               ack_d_q, ack_d_d, ack_i_q, ack_i_d;
  logic               clr_cnt;
  logic [31:0]        cnt_read_q, cnt_write_q, cnt_fetch_q;
  logic               head_vld, sending, d_fire, i_fire;
  logic               is_d, is_ifetch, is_inval, is_print, is_clr, is_bad;
  logic [TAG_W-1:0]   tag_f;
  logic [INDEX_W-1:0] index_f;
  logic [OFFSET_W-1:0] offset_f;

  assign push_entry = '{cmd: in_cmd, addr: in_addr};
  assign push       = in_valid && !fifo_full;
  assign in_ready   = !fifo_full;

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    is_d = 1'b0; is_ifetch = 1'b0; is_inval = 1'b0;
    is_print = 1'b0; is_clr = 1'b0; is_bad = 1'b0;
    case (head.cmd)
      READ, WRITE, L2_DATA_RQ: is_d      = 1'b1;
      L2_INVAL:                is_inval  = 1'b1;
      I_FETCH:                 is_ifetch = 1'b1;
      CLR:                     is_clr    = 1'b1;
      PRINT:                   is_print  = 1'b1;
      default:                 is_bad    = 1'b1;
    endcase
  end

  assign head_vld = !fifo_empty;
  assign sending  = (state_q == S_SEND) && head_vld;
  assign d_valid  = sending && (is_d || (is_inval && !d_done_q));
  assign i_valid  = sending && (is_ifetch || (is_inval && !i_done_q));
  assign d_fire   = d_valid && d_ready;
  assign i_fire   = i_valid && i_ready;

  // Fields are zeroed while the FIFO is empty so idle outputs read as reset values.
  assign tag_f    = head_vld ? head.addr[ADDR_W-1:OFFSET_W+INDEX_W] : '0;
  assign index_f  = head_vld ? head.addr[OFFSET_W+INDEX_W-1:OFFSET_W] : '0;
  assign offset_f = head_vld ? head.addr[OFFSET_W-1:0] : '0;
  assign d_tag    = tag_f;
  assign d_index  = index_f;
  assign d_offset = offset_f;
  assign i_tag    = tag_f;
  assign i_index  = index_f;
  assign i_offset = offset_f;
  assign d_cmd    = head_vld ? head.cmd : '0;
  assign i_inval  = head_vld && is_inval;

  assign clr_req     = (state_q == S_CLR_WAIT);
  assign print_pulse = sending && is_print;
  assign bad_cmd     = sending && is_bad;
  assign busy        = head_vld || clr_req;
  assign more        = push || (fifo_count > CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    clr_cnt  = 1'b0;
    d_done_d = d_done_q;
    i_done_d = i_done_q;
    ack_d_d  = ack_d_q;
    ack_i_d  = ack_i_q;
    case (state_q)
      S_IDLE: if (head_vld || push) state_d = S_SEND;
      S_SEND: begin
        if (!head_vld) begin
          state_d = S_IDLE;
        end else if (is_clr) begin
          state_d = S_CLR_WAIT;
        end else if (is_inval) begin
          if ((d_done_q || d_fire) && (i_done_q || i_fire)) begin
            pop      = 1'b1;
            d_done_d = 1'b0;
            i_done_d = 1'b0;
          end else begin
            d_done_d = d_done_q || d_fire;
            i_done_d = i_done_q || i_fire;
          end
        end else if (is_d) begin
          pop = d_fire;
        end else if (is_ifetch) begin
          pop = i_fire;
        end else begin
          pop = 1'b1;
        end
      end
      S_CLR_WAIT: begin
        if ((ack_d_q || clr_ack_d) && (ack_i_q || clr_ack_i)) begin
          pop     = 1'b1;
          clr_cnt = 1'b1;
          ack_d_d = 1'b0;
          ack_i_d = 1'b0;
        end else begin
          ack_d_d = ack_d_q || clr_ack_d;
          ack_i_d = ack_i_q || clr_ack_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) state_d = more ? S_SEND : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      d_done_q <= 1'b0;
      i_done_q <= 1'b0;
      ack_d_q  <= 1'b0;
      ack_i_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_done_q <= d_done_d;
      i_done_q <= i_done_d;
      ack_d_q  <= ack_d_d;
      ack_i_q  <= ack_i_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_read_q  <= '0;
      cnt_write_q <= '0;
      cnt_fetch_q <= '0;
    end else if (clr_cnt) begin
      cnt_read_q  <= '0;
      cnt_write_q <= '0;
      cnt_fetch_q <= '0;
    end else begin
      if (d_fire && head.cmd == READ)    cnt_read_q  <= sat_inc(cnt_read_q);
      if (d_fire && head.cmd == WRITE)   cnt_write_q <= sat_inc(cnt_write_q);
      if (i_fire && head.cmd == I_FETCH) cnt_fetch_q <= sat_inc(cnt_fetch_q);
    end
  end

  assign cnt_read  = cnt_read_q;
  assign cnt_write = cnt_write_q;
  assign cnt_fetch = cnt_fetch_q;
endmodule
`default_nettype wire

// File: tb/tb_cache_cmd_dispatch.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cache_cmd_dispatch : directed + random stimulus against a queue-based model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_cache_cmd_dispatch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, d_ready = 1'b0, i_ready = 1'b0;
  logic        clr_ack_d = 1'b0, clr_ack_i = 1'b0;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_addr = '0;
  logic        in_ready, d_valid, i_valid, i_inval, clr_req, print_pulse, bad_cmd, busy;
  logic [3:0]  d_cmd;
  logic [11:0] d_tag, i_tag;
  logic [13:0] d_index, i_index;
  logic [5:0]  d_offset, i_offset;
  logic [31:0] cnt_read, cnt_write, cnt_fetch;

  cache_cmd_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .d_valid(d_valid), .d_ready(d_ready), .d_cmd(d_cmd),
    .d_tag(d_tag), .d_index(d_index), .d_offset(d_offset),
    .i_valid(i_valid), .i_ready(i_ready), .i_inval(i_inval),
    .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
    .clr_req(clr_req), .clr_ack_d(clr_ack_d), .clr_ack_i(clr_ack_i),
    .print_pulse(print_pulse), .bad_cmd(bad_cmd),
    .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_fetch(cnt_fetch),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
  } ent_t;

  ent_t        mq[$];
  bit          m_dsent, m_isent, m_clr_phase, m_ackd, m_acki;
  logic [31:0] m_rd, m_wr, m_fe;
  int          n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_dk(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd1) || (c == 4'd3) || (c == 4'd4);
  endfunction

  function automatic bit is_undef(input logic [3:0] c);
    return !((c <= 4'd4) || (c == 4'd8) || (c == 4'd9));
  endfunction

  function automatic bit exp_dv();
    if (mq.size() == 0) return 1'b0;
    return is_dk(mq[0].cmd) && !(mq[0].cmd == 4'd3 && m_dsent);
  endfunction

  function automatic bit exp_iv();
    if (mq.size() == 0) return 1'b0;
    return (mq[0].cmd == 4'd2) || (mq[0].cmd == 4'd3 && !m_isent);
  endfunction

  function automatic bit head_is(input logic [3:0] c);
    return (mq.size() != 0) && (mq[0].cmd == c);
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_dsent = 0; m_isent = 0; m_clr_phase = 0; m_ackd = 0; m_acki = 0;
    m_rd = 0; m_wr = 0; m_fe = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] a;
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("d_valid", d_valid, exp_dv());
    check("i_valid", i_valid, exp_iv());
    check("clr_req", clr_req, head_is(4'd8) && m_clr_phase);
    check("print_pulse", print_pulse, head_is(4'd9));
    check("bad_cmd", bad_cmd, (mq.size() != 0) && is_undef(mq[0].cmd));
    check("busy", busy, mq.size() != 0);
    check("cnt_read", cnt_read, m_rd);
    check("cnt_write", cnt_write, m_wr);
    check("cnt_fetch", cnt_fetch, m_fe);
    if (mq.size() != 0) begin
      a = mq[0].addr;
      if (exp_dv()) begin
        check("d_cmd", d_cmd, mq[0].cmd);
        check("d_tag", d_tag, a >> 20);
        check("d_index", d_index, (a >> 6) & 32'h3FFF);
        check("d_offset", d_offset, a & 32'h3F);
      end
      if (exp_iv()) begin
        check("i_inval", i_inval, mq[0].cmd == 4'd3);
        check("i_tag", i_tag, a >> 20);
        check("i_index", i_index, (a >> 6) & 32'h3FFF);
        check("i_offset", i_offset, a & 32'h3F);
      end
    end
  endtask

  task automatic model_update(input bit iv, input logic [3:0] ic, input logic [31:0] ia,
                              input bit dr, input bit ir, input bit ad, input bit ai);
    bit fd, fi, pop, acc;
    fd  = exp_dv() && dr;
    fi  = exp_iv() && ir;
    pop = 0;
    acc = iv && (mq.size() < DEPTH);
    if (mq.size() != 0) begin
      case (mq[0].cmd)
        4'd0, 4'd1, 4'd4: begin
          pop = fd;
          if (fd && mq[0].cmd == 4'd0) m_rd = sat(m_rd);
          if (fd && mq[0].cmd == 4'd1) m_wr = sat(m_wr);
        end
        4'd2: begin
          pop = fi;
          if (fi) m_fe = sat(m_fe);
        end
        4'd3: begin
          if ((m_dsent || fd) && (m_isent || fi)) begin
            pop = 1; m_dsent = 0; m_isent = 0;
          end else begin
            m_dsent = m_dsent || fd; m_isent = m_isent || fi;
          end
        end
        4'd8: begin
          if (!m_clr_phase) m_clr_phase = 1;
          else begin
            m_ackd = m_ackd || ad; m_acki = m_acki || ai;
            if (m_ackd && m_acki) begin
              pop = 1; m_rd = 0; m_wr = 0; m_fe = 0;
              m_ackd = 0; m_acki = 0; m_clr_phase = 0;
            end
          end
        end
        default: pop = 1;
      endcase
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back('{cmd: ic, addr: ia});
  endtask

  task automatic step(input bit iv, input logic [3:0] ic, input logic [31:0] ia,
                      input bit dr, input bit ir, input bit ad, input bit ai);
    @(negedge clk);
    check_outputs();
    in_valid = iv; in_cmd = ic; in_addr = ia;
    d_ready = dr; i_ready = ir; clr_ack_d = ad; clr_ack_i = ai;
    model_update(iv, ic, ia, dr, ir, ad, ai);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_in_ready"}, in_ready, 1);
    check({p, "_d_valid"}, d_valid, 0);
    check({p, "_i_valid"}, i_valid, 0);
    check({p, "_clr_req"}, clr_req, 0);
    check({p, "_print"}, print_pulse, 0);
    check({p, "_bad"}, bad_cmd, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_cnts"}, {cnt_read, cnt_write}, 0);
    check({p, "_cnt_fetch"}, cnt_fetch, 0);
    check({p, "_d_fields"}, {d_cmd, d_tag, d_index, d_offset}, 0);
    check({p, "_i_fields"}, {i_inval, i_tag, i_index, i_offset}, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    model_reset();
    in_valid = 0; in_cmd = 0; in_addr = 0;
    d_ready = 0; i_ready = 0; clr_ack_d = 0; clr_ack_i = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] pick_cmd();
    int s, b;
    s = $urandom_range(0, 19);
    if (s < 14) return 4'(s % 5);
    if (s < 16) return 4'd9;
    if (s == 16) return 4'd8;
    b = $urandom_range(0, 8);
    return (b < 3) ? 4'(5 + b) : 4'(10 + b - 3);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout at %0t, expected $finish", $time);
    $fatal(1);
  end

  initial begin
    int k, pv, pd, pi;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("rst0");
    rst_n = 1'b1;

    // Single READ: fields and one-cycle latency
    step(1, 4'd0, 32'h1234_5678, 1, 1, 0, 0);
    step(0, 4'd0, 32'h0, 1, 1, 0, 0);
    check("tp1_dvalid", d_valid, 1);
    check("tp1_tag", d_tag, 12'h123);
    check("tp1_index", d_index, 14'h1159);
    check("tp1_offset", d_offset, 6'h38);
    check("tp1_ivalid", i_valid, 0);
    step(0, 4'd0, 32'h0, 1, 1, 0, 0);
    check("tp1_cnt_read", cnt_read, 1);

    // Fill the FIFO while D is stalled, then drain in order
    for (int i = 0; i < 4; i++) step(1, 4'(i % 2), 32'h0000_1000 * (i + 1) + i, 0, 0, 0, 0);
    step(1, 4'd0, 32'hABCD_0041, 0, 0, 0, 0);
    check("tp2_full", in_ready, 0);
    k = 0;
    while (in_ready !== 1'b1 && k < 10) begin
      step(1, 4'd0, 32'hABCD_0041, 1, 1, 0, 0);
      k++;
    end
    step(1, 4'd0, 32'hABCD_0041, 1, 1, 0, 0);
    k = 0;
    do begin step(0, 4'd0, 32'h0, 1, 1, 0, 0); k++; end while (busy && k < 20);
    check("tp2_drained", busy, 0);

    // Broadcast invalidate: I completes first, D held
    step(1, 4'd3, 32'hDEAD_BEEF, 0, 1, 0, 0);
    step(0, 4'd0, 32'h0, 0, 1, 0, 0);
    step(0, 4'd0, 32'h0, 0, 1, 0, 0);
    check("tp3_ivalid_dropped", i_valid, 0);
    check("tp3_dvalid_held", d_valid, 1);
    step(0, 4'd0, 32'h0, 0, 1, 0, 0);
    check("tp3_busy_held", busy, 1);
    step(0, 4'd0, 32'h0, 1, 0, 0, 0);
    step(0, 4'd0, 32'h0, 1, 0, 0, 0);
    check("tp3_popped", busy, 0);

    // Counters, then CLR with staggered acks
    step(1, 4'd0, 32'h100, 1, 1, 0, 0);
    step(1, 4'd0, 32'h200, 1, 1, 0, 0);
    step(1, 4'd0, 32'h300, 1, 1, 0, 0);
    step(1, 4'd1, 32'h400, 1, 1, 0, 0);
    step(1, 4'd1, 32'h500, 1, 1, 0, 0);
    step(1, 4'd2, 32'h600, 1, 1, 0, 0);
    step(1, 4'd8, 32'h0, 1, 1, 0, 0);
    k = 0;
    do begin step(0, 4'd0, 32'h0, 1, 1, 0, 0); k++; end while (!clr_req && k < 30);
    check("tp4_clr_seen", clr_req, 1);
    step(0, 4'd0, 32'h0, 1, 1, 0, 1);
    step(0, 4'd0, 32'h0, 1, 1, 0, 0);
    step(0, 4'd0, 32'h0, 1, 1, 1, 0);
    check("tp4_clr_held", clr_req, 1);
    step(0, 4'd0, 32'h0, 1, 1, 0, 0);
    check("tp4_clr_fall", clr_req, 0);
    check("tp4_cnt_zero", {cnt_read, cnt_write, cnt_fetch}, 0);

    // Bad code then PRINT
    step(1, 4'd6, 32'h0, 1, 1, 0, 0);
    step(1, 4'd9, 32'h0, 1, 1, 0, 0);
    check("tp5_bad", bad_cmd, 1);
    step(0, 4'd0, 32'h0, 1, 1, 0, 0);
    check("tp5_print", print_pulse, 1);
    check("tp5_bad_gone", bad_cmd, 0);
    check("tp5_no_valid", {d_valid, i_valid}, 0);
    step(0, 4'd0, 32'h0, 1, 1, 0, 0);

    // Reset while waiting for CLR acks with two entries queued
    step(1, 4'd8, 32'h0, 0, 0, 0, 0);
    step(1, 4'd0, 32'h111, 0, 0, 0, 0);
    step(1, 4'd1, 32'h222, 0, 0, 0, 0);
    step(0, 4'd0, 32'h0, 0, 0, 0, 0);
    check("tp6_clr_wait", clr_req, 1);
    async_reset();
    step(0, 4'd0, 32'h0, 1, 1, 1, 1);
    step(0, 4'd0, 32'h0, 1, 1, 0, 0);
    check("tp6_idle_busy", busy, 0);
    check("tp6_idle_clr", clr_req, 0);

    // Random traffic
    for (int seg = 0; seg < 8; seg++) begin
      pv = $urandom_range(20, 100);
      pd = $urandom_range(20, 100);
      pi = $urandom_range(20, 100);
      for (int c = 0; c < 450; c++) begin
        step($urandom_range(0, 99) < pv, pick_cmd(), $urandom,
             $urandom_range(0, 99) < pd, $urandom_range(0, 99) < pi,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end
    k = 0;
    do begin step(0, 4'd0, 32'h0, 1, 1, 1, 1); k++; end while (busy && k < 40);
    step(0, 4'd0, 32'h0, 1, 1, 0, 0);
    check("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
